lsu_ctrl: RTL and testbench

Load/store sequencer between the execute stage and the single-port data memory. It accepts one RV32I memory op at a time and handles byte/half/word address lanes, sign/zero extension and misalignment checks. Sub-word stores are done as a read-modify-write (RMW) on the word-wide memory port. It drives the data memory's write enable, word address and write data, and tells the pipeline when it can issue the next op.

---
 rtl/lsu_if.sv | 34 +++
 rtl/lsu_ctrl.sv | 142 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// Execute-stage / data-memory bundle for the load/store sequencer.
// master: pipeline and memory side; slave: lsu_ctrl.
interface lsu_if #(
   parameter int AW = 10,
   parameter int DW = 32
);
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [2:0]    req_funct3;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          resp_valid;
   logic          resp_err;
   logic [31:0]   resp_rdata;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      output mem_rdata,
      input  req_ready, resp_valid, resp_err, resp_rdata,
      input  mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  mem_rdata,
      output req_ready, resp_valid, resp_err, resp_rdata,
      output mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/lsu_ctrl.sv
// RV32I load/store sequencer on a single-port, word-wide data memory.
// Sub-word stores are read-modify-write; misaligned/illegal ops are rejected.
module lsu_ctrl #(
   parameter int DMEM_ADDR_WIDTH = 10,
   parameter int DMEM_DATA_WIDTH = 32
) (
   input logic  clk,
   input logic  rst_n,
   lsu_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE, RD, MRG, WR, RESP
   } state_t;

   state_t                       state;
   logic                         we_q;
   logic [2:0]                   f3_q;
   logic [1:0]                   off_q;
   logic [31:0]                  wdata_q;
   logic                         err_q;
   logic                         resp_valid_q;
   logic                         resp_err_q;
   logic [31:0]                  resp_rdata_q;
   logic                         mem_we_q;
   logic [DMEM_ADDR_WIDTH-1:0]   mem_addr_q;
   logic [31:0]                  mem_wdata_q;

   logic [DMEM_DATA_WIDTH-1:0]   rd_word;
   logic [2:0]                   f3;
   logic [1:0]                   lo;
   logic                         illegal;
   logic                         misal;
   logic                         bad;
   logic [7:0]                   lane_b;
   logic [15:0]                  lane_h;
   logic [31:0]                  ld;
   logic [31:0]                  merged;
   logic                         unused_addr;

   assign rd_word     = bus.mem_rdata;
   assign f3          = bus.req_funct3;
   assign lo          = bus.req_addr[1:0];
   assign unused_addr = ^bus.req_addr[31:DMEM_ADDR_WIDTH+2];

   assign illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11)
                 || (bus.req_we && f3[2]);
   assign misal   = (f3[1:0] == 2'b01 && lo[0])
                 || (f3[1:0] == 2'b10 && lo != 2'b00);
   assign bad     = illegal || misal;

   assign lane_b = rd_word[{off_q, 3'b000} +: 8];
   assign lane_h = rd_word[{off_q[1], 4'b0000} +: 16];

   always_comb begin
      case (f3_q)
         3'b000:  ld = {{24{lane_b[7]}}, lane_b};
         3'b001:  ld = {{16{lane_h[15]}}, lane_h};
         3'b100:  ld = {24'h0, lane_b};
         3'b101:  ld = {16'h0, lane_h};
         default: ld = rd_word[31:0];
      endcase
   end

   // Replace only the addressed lane; funct3[0] selects half vs byte.
   always_comb begin
      merged = rd_word[31:0];
      if (f3_q[0])
         merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      else
         merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         we_q         <= 1'b0;
         f3_q         <= 3'b000;
         off_q        <= 2'b00;
         wdata_q      <= 32'h0;
         err_q        <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= 32'h0;
      end else begin
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         mem_we_q     <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  we_q    <= bus.req_we;
                  f3_q    <= f3;
                  off_q   <= lo;
                  wdata_q <= bus.req_wdata;
                  err_q   <= bad;
                  if (bad) begin
                     state <= RESP;
                  end else begin
                     mem_addr_q <= bus.req_addr[DMEM_ADDR_WIDTH+1:2];
                     if (bus.req_we && f3 == 3'b010) begin
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= bus.req_wdata;
                        state       <= WR;
                     end else begin
                        state <= RD;
                     end
                  end
               end
            end
            RD: state <= MRG;
            MRG: begin
               if (we_q) begin
                  mem_we_q    <= 1'b1;
                  mem_wdata_q <= merged;
                  state       <= WR;
               end else begin
                  resp_rdata_q <= ld;
                  state        <= RESP;
               end
            end
            WR: state <= RESP;
            RESP: begin
               resp_valid_q <= 1'b1;
               resp_err_q   <= err_q;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready  = (state == IDLE);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = {{(DMEM_DATA_WIDTH-32){1'b0}}, mem_wdata_q};
endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: byte-level memory model, randomized ops.
// Driver pushes expected responses/writes; a negedge monitor pops and compares.
module tb_lsu_ctrl;
   localparam int AW = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lsu_if #(.AW(AW), .DW(32)) bus ();

   lsu_ctrl #(
      .DMEM_ADDR_WIDTH(AW),
      .DMEM_DATA_WIDTH(32)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // Synchronous-read data memory
   logic [31:0] mem [0:1023];
   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
   end

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
      logic [31:0] at;
   } exp_t;

   typedef struct packed {
      logic [9:0]  a;
      logic [31:0] d;
   } wr_t;

   exp_t        rq[$];
   wr_t         wq[$];
   int unsigned resp_cyc[$];
   logic [7:0]  rb [0:4095];
   logic [31:0] last_rd = 32'h0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Reference: byte-addressed memory, size from funct3, plain arithmetic
   task automatic model(input bit we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int unsigned c);
      int          size;
      int          a;
      int          lat;
      bit          legal;
      logic [31:0] v;
      exp_t        e;
      wr_t         w;
      size = 1 << f3[1:0];
      a = int'(addr[11:0]);
      if (we) legal = (f3 inside {3'd0, 3'd1, 3'd2});
      else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      e.err = 1'b0;
      if (!legal || (a % size) != 0) begin
         e.err = 1'b1;
         lat = 1;
      end else if (we) begin
         for (int i = 0; i < size; i++) rb[a + i] = wd[8*i +: 8];
         a = a - (a % 4);
         w.a = 10'(a / 4);
         w.d = {rb[a+3], rb[a+2], rb[a+1], rb[a]};
         wq.push_back(w);
         lat = (size == 4) ? 2 : 4;
      end else begin
         v = 32'h0;
         for (int i = 0; i < size; i++) v = v | (32'(rb[a + i]) << (8*i));
         if (!f3[2] && size < 4 && v[8*size-1])
            v = v | (32'hFFFF_FFFF << (8*size));
         last_rd = v;
         lat = 3;
      end
      e.rdata = last_rd;
      e.at = c + 1 + lat;
      rq.push_back(e);
   endtask

   // Called and returns at a negedge
   task automatic issue(input bit we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input bit hold);
      int n = 0;
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_wdata  = d;
      while (!bus.req_ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) begin
         errors++;
         $display("FAIL accept_timeout: req_ready stuck low at cycle %0d",
                  cyc);
         bus.req_valid = 1'b0;
         return;
      end
      model(we, f3, a, d, cyc);
      @(negedge clk);
      if (!hold) bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((rq.size() != 0 || wq.size() != 0) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (rq.size() != 0 || wq.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d resp / %0d writes outstanding",
                  rq.size(), wq.size());
         rq.delete();
         wq.delete();
      end
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      exp_t e;
      wr_t  w;
      if (bus.resp_valid) begin
         resp_cyc.push_back(cyc);
         if (rq.size() == 0) begin
            chk("unexpected_resp", 32'd1, 32'd0);
         end else begin
            e = rq.pop_front();
            chk("resp_err", 32'(bus.resp_err), 32'(e.err));
            chk("resp_rdata", bus.resp_rdata, e.rdata);
            chk("resp_cycle", cyc, e.at);
         end
      end
      if (bus.mem_we) begin
         if (wq.size() == 0) begin
            chk("unexpected_mem_we", 32'd1, 32'd0);
         end else begin
            w = wq.pop_front();
            chk("mem_addr", 32'(bus.mem_addr), 32'(w.a));
            chk("mem_wdata", bus.mem_wdata, w.d);
         end
      end
   end

   initial begin
      int k;
      bit we;
      logic [2:0] f3;
      logic [31:0] a;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      for (int i = 0; i < 4096; i++) rb[i] = 8'h0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;

      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
      chk("rst_rdata", bus.resp_rdata, 32'h0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0);
      issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
      drain();
      chk("lw_0x10", bus.resp_rdata, 32'hDEAD_BEEF);

      issue(1'b1, 3'b010, 32'h20, 32'h8000_80F0, 1'b0);
      issue(1'b0, 3'b000, 32'h20, 32'h0, 1'b0);
      drain();
      chk("lb_0x20", bus.resp_rdata, 32'hFFFF_FFF0);
      issue(1'b0, 3'b100, 32'h20, 32'h0, 1'b0);
      drain();
      chk("lbu_0x20", bus.resp_rdata, 32'h0000_00F0);
      issue(1'b0, 3'b001, 32'h22, 32'h0, 1'b0);
      drain();
      chk("lh_0x22", bus.resp_rdata, 32'hFFFF_8000);
      issue(1'b0, 3'b101, 32'h22, 32'h0, 1'b0);
      drain();
      chk("lhu_0x22", bus.resp_rdata, 32'h0000_8000);

      issue(1'b1, 3'b010, 32'h30, 32'h1122_3344, 1'b0);
      issue(1'b1, 3'b000, 32'h31, 32'h0000_00AB, 1'b0);
      drain();
      chk("sb_0x31_mem", mem[12], 32'h1122_AB44);
      issue(1'b1, 3'b001, 32'h32, 32'h0000_CDEF, 1'b0);
      drain();
      chk("sh_0x32_mem", mem[12], 32'hCDEF_AB44);

      // Rejected ops leave resp_rdata at the 0x8000 LHU result
      issue(1'b0, 3'b001, 32'h41, 32'h0, 1'b0);
      issue(1'b0, 3'b010, 32'h42, 32'h0, 1'b0);
      issue(1'b1, 3'b010, 32'h43, 32'h5555_5555, 1'b0);
      issue(1'b0, 3'b011, 32'h40, 32'h0, 1'b0);
      drain();
      chk("err_rdata_kept", bus.resp_rdata, 32'h0000_8000);

      // Reset during MRG of an SB
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h31;
      bus.req_wdata  = 32'h0000_0077;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("ready_in_reset", 32'(bus.req_ready), 32'd1);
      chk("mem_we_in_reset", 32'(bus.mem_we), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      last_rd = 32'h0;
      @(negedge clk);
      chk("ready_after_reset", 32'(bus.req_ready), 32'd1);
      chk("rdata_after_reset", bus.resp_rdata, 32'h0);
      issue(1'b0, 3'b010, 32'h30, 32'h0, 1'b0);
      drain();
      chk("lw_after_reset", bus.resp_rdata, 32'hCDEF_AB44);

      // Three loads with req_valid held high
      k = resp_cyc.size();
      issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
      issue(1'b0, 3'b000, 32'h21, 32'h0, 1'b1);
      issue(1'b0, 3'b101, 32'h32, 32'h0, 1'b0);
      drain();
      if (resp_cyc.size() >= k + 3) begin
         chk("b2b_gap0", resp_cyc[k+1] - resp_cyc[k], 32'd4);
         chk("b2b_gap1", resp_cyc[k+2] - resp_cyc[k+1], 32'd4);
      end else begin
         chk("b2b_count", 32'(resp_cyc.size() - k), 32'd3);
      end

      for (int i = 0; i < 300; i++) begin
         we = 1'($urandom % 2);
         f3 = 3'($urandom % 8);
         a  = 32'(($urandom % 16) * 4);
         if ($urandom % 3 == 0) a = a + 32'($urandom % 4);
         if ($urandom % 8 == 0) a = a | 32'h0000_5000;
         issue(we, f3, a, $urandom, 1'($urandom % 2));
      end
      bus.req_valid = 1'b0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
